// File: rtl/mips_muldiv.sv
// ============================================================================
// mips_muldiv : multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mips_muldiv #(
  parameter int               WIDTH          = 32,
  parameter bit               FAST_MUL       = 1'b0,
  parameter logic [WIDTH-1:0] DIV_BY_ZERO_LO = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_is_div;
  logic               r_dz;
  logic               r_neg_lo;
  logic               r_neg_hi;

  logic               w_is_mul;
  logic               w_is_div;
  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_is_mul = (op == 3'd0) || (op == 3'd1);
  assign w_is_div = (op == 3'd2) || (op == 3'd3);
  assign w_signed = (op == 3'd0) || (op == 3'd2);
  assign w_sa     = w_signed & rs_val[WIDTH-1];
  assign w_sb     = w_signed & rt_val[WIDTH-1];
  assign w_abs_a  = w_sa ? -rs_val : rs_val;
  assign w_abs_b  = w_sb ? -rt_val : rt_val;

  // Multiply: multiplier sits in the low half and is consumed LSB first.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_a : {WIDTH{1'b0}})};

  // Divide: {remainder, dividend/quotient}; one restoring trial per cycle.
  assign w_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff  = w_shift - {1'b0, r_b};

  assign w_prod   = FAST_MUL ? ({{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b}) : r_acc;
  assign w_prod_s = r_neg_lo ? -w_prod : w_prod;
  assign w_quot   = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem    = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            if (w_is_mul || w_is_div) begin
              r_a      <= w_abs_a;
              r_b      <= w_abs_b;
              r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
              r_is_div <= w_is_div;
              r_neg_lo <= w_sa ^ w_sb;
              r_neg_hi <= w_sa;
              r_cnt    <= CW'(WIDTH - 1);
              r_dz     <= 1'b0;
              busy     <= 1'b1;
              if (w_is_div && (rt_val == '0)) begin
                r_dz    <= 1'b1;
                r_a     <= rs_val;
                r_state <= S_FIX;
              end else if (w_is_mul && FAST_MUL) begin
                r_state <= S_FIX;
              end else begin
                r_state <= S_CALC;
              end
            end else if (op == 3'd4) begin
              hi <= rs_val;
            end else if (op == 3'd5) begin
              lo <= rs_val;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            if (r_is_div) begin
              if (!w_diff[WIDTH])
                r_acc <= {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
              else
                r_acc <= {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end else begin
              r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            end
            if (r_cnt == '0)
              r_state <= S_FIX;
            else
              r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (r_dz) begin
              hi <= r_a;
              lo <= DIV_BY_ZERO_LO;
            end else if (r_is_div) begin
              hi <= w_rem;
              lo <= w_quot;
            end else begin
              {hi, lo} <= w_prod_s;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_muldiv.sv
// ============================================================================
// tb_mips_muldiv : iterative and single-cycle-multiply instances vs. an
// arithmetic reference model. Revision 1.0
// ============================================================================
`default_nettype none

module tb_mips_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         flush;
  logic [2:0]   op;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic         busy_s, done_s, busy_f, done_f;
  logic [W-1:0] hi_s, lo_s, hi_f, lo_f;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mips_muldiv #(.WIDTH(W), .FAST_MUL(1'b0)) dut_s (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .flush(flush), .busy(busy_s), .done(done_s),
    .hi(hi_s), .lo(lo_s));

  mips_muldiv #(.WIDTH(W), .FAST_MUL(1'b1)) dut_f (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .flush(flush), .busy(busy_f), .done(done_f),
    .hi(hi_f), .lo(lo_f));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on the architectural result.
  task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint       p;
    logic [63:0]  u;
    int           q, r;
    case (o)
      3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; end
      3'd1: begin u = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = u; end
      3'd2: begin
        if (b == 0) begin m_hi = a; m_lo = '1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 0; end
        else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          m_lo = q; m_hi = r;
        end
      end
      3'd3: begin
        if (b == 0) begin m_hi = a; m_lo = '1; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat_s = -1, lat_f = -1, nd_s = 0, nd_f = 0;
    int exp_s, exp_f;
    logic [W-1:0] cap_hs = '0, cap_ls = '0, cap_hf = '0, cap_lf = '0;
    logic dz, arith;
    arith = (o <= 3'd3);
    dz    = (o == 3'd2 || o == 3'd3) && (b == 0);
    exp_s = dz ? 1 : W + 1;
    exp_f = (dz || o <= 3'd1) ? 1 : W + 1;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; rs_val = $urandom; rt_val = $urandom;
    model(o, a, b);
    check($sformatf("busy_s_op%0d", o), {63'b0, busy_s}, {63'b0, arith});
    check($sformatf("busy_f_op%0d", o), {63'b0, busy_f}, {63'b0, arith});
    for (int k = 1; k <= W + 4; k++) begin
      @(negedge clk);
      if (done_s) begin
        nd_s++;
        if (lat_s < 0) begin lat_s = k; cap_hs = hi_s; cap_ls = lo_s; end
      end
      if (done_f) begin
        nd_f++;
        if (lat_f < 0) begin lat_f = k; cap_hf = hi_f; cap_lf = lo_f; end
      end
    end
    if (arith) begin
      check($sformatf("lat_s_op%0d", o), 64'(lat_s), 64'(exp_s));
      check($sformatf("lat_f_op%0d", o), 64'(lat_f), 64'(exp_f));
      check($sformatf("ndone_s_op%0d", o), 64'(nd_s), 64'd1);
      check($sformatf("ndone_f_op%0d", o), 64'(nd_f), 64'd1);
      check($sformatf("hilo_s_op%0d", o), {cap_hs, cap_ls}, {m_hi, m_lo});
      check($sformatf("hilo_f_op%0d", o), {cap_hf, cap_lf}, {m_hi, m_lo});
    end else begin
      check($sformatf("ndone_s_op%0d", o), 64'(nd_s), 64'd0);
      check($sformatf("ndone_f_op%0d", o), 64'(nd_f), 64'd0);
    end
    check($sformatf("hold_s_op%0d", o), {hi_s, lo_s}, {m_hi, m_lo});
    check($sformatf("hold_f_op%0d", o), {hi_f, lo_f}, {m_hi, m_lo});
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;
    int           nd;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    check("reset_s", {busy_s, done_s, hi_s, lo_s}, 66'b0);
    check("reset_f", {busy_f, done_f, hi_f, lo_f}, 66'b0);
    reset = 1'b0;

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd3, 32'd100, 32'd0);
    run_op(3'd4, 32'h1234, 32'd0);
    run_op(3'd5, 32'h5678, 32'd0);
    run_op(3'd6, 32'hDEAD, 32'hBEEF);

    // Flush mid-divide, with a stray start issued while busy.
    nd = 0;
    @(negedge clk);
    start = 1'b1; op = 3'd3; rs_val = 32'd1000; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 4) begin start = 1'b1; op = 3'd1; rs_val = 32'd3; rt_val = 32'd3; end
      if (k == 5) start = 1'b0;
      if (k == 9) flush = 1'b1;
      @(negedge clk);
      if (k == 6) check("busy_after_stray_start", {62'b0, busy_s, busy_f}, 64'd3);
      if (k == 10) begin
        flush = 1'b0;
        check("busy_after_flush", {62'b0, busy_s, busy_f}, 64'd0);
      end
      if (done_s || done_f) nd++;
    end
    check("flush_no_done", 64'(nd), 64'd0);
    check("flush_hilo_s", {hi_s, lo_s}, {m_hi, m_lo});
    check("flush_hilo_f", {hi_f, lo_f}, {m_hi, m_lo});

    // start together with flush in IDLE is dropped.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd4; rs_val = 32'hCAFE;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush_drop", {hi_s, hi_f}, {m_hi, m_hi});

    // Reset in the middle of a MULT.
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs_val = 32'd123; rt_val = 32'hFFFF_FF00;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 14) reset = 1'b1;
      @(negedge clk);
      if (k == 15) begin
        reset = 1'b0;
        check("midop_reset_s", {busy_s, done_s, hi_s, lo_s}, 66'b0);
        check("midop_reset_f", {busy_f, done_f, hi_f, lo_f}, 66'b0);
      end
      if (k > 15 && (done_s || done_f)) nd++;
    end
    check("reset_no_done", 64'(nd), 64'd0);
    m_hi = '0; m_lo = '0;
    run_op(3'd1, 32'd6, 32'd7);

    for (int i = 0; i < 20; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = '1; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = -ra;
        default: ;
      endcase
      run_op(ro, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
Parametrised multi-cycle multiply/divide unit with HI/LO result registers for the next-generation MIPS pipeline. It replaces the single-cycle combinational MUL path with the full MULT/MULTU/DIV/DIVU/MTHI/MTLO set. Word width is generic, and multiply can run iteratively or in a single cycle. It sits beside the execute-stage ALU; decode stalls on busy before issuing MFHI/MFLO or a new muldiv op.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (≥4, even).
FAST_MUL, 0, 1 = single-cycle multiply; 0 = iterative shift-add multiply.
DIV_BY_ZERO_LO, all-ones, value loaded into LO on divide by zero.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  issue request, sampled on clk
op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, 6/7 reserved
rs_val  input  WIDTH  operand A (multiplicand/dividend/MT source)
rt_val  input  WIDTH  operand B (multiplier/divisor)
flush  input  1  abort in-flight op (pipeline squash)
busy  output  1  op in progress; HI/LO not valid
done  output  1  one-cycle pulse, HI/LO just updated by mul/div
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0, iteration counter=0. Reset overrides start/flush and aborts any op mid-calculation.
- States: IDLE, CALC, FIX.
- IDLE + start + op∈{0..3}: latch operands. Signed ops (0, 2) take absolute values and record the result sign (MULT: signA^signB; DIV quotient: signA^signB; remainder: signA). Go to CALC; busy=1 from the next cycle.
- FAST_MUL=1 with op∈{0,1}: skip CALC and go straight to FIX. The product is computed in FIX.
- CALC: one bit per cycle for WIDTH cycles (counter WIDTH-1 down to 0), then FIX.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring division producing WIDTH quotient bits.
- FIX: apply two's-complement sign correction, write {hi,lo}, pulse done=1, set busy=0, return to IDLE.
  - Multiply: {hi,lo} = 2·WIDTH-bit product.
  - Divide: lo = quotient, hi = remainder. Remainder carries the dividend's sign; quotient truncates toward zero.
- Latency (start sampled at edge 0): iterative ops write HI/LO at edge WIDTH+1, with done high the cycle after; FAST_MUL multiply writes at edge 1.
- Divide by zero, detected at start: bypass CALC, go to FIX, lo=DIV_BY_ZERO_LO, hi=rs_val unchanged. Latency is the same as FAST_MUL.
- Signed overflow (MIN / -1): lo=MIN, hi=0. No exception.
- MTHI/MTLO (op 4/5) in IDLE: hi or lo ← rs_val at the next edge. busy and done stay 0.
- Reserved ops: ignored.
- start while busy: ignored, with no effect on the in-flight op. Decode must not issue while busy.
- start in the FIX cycle: ignored; busy is still 1 in that cycle.
- flush while busy: return to IDLE at the next edge. hi/lo keep their pre-op values, done is not asserted, busy=0 the next cycle.
- flush in IDLE: no effect. flush together with start in IDLE: start is dropped.
- hi/lo change only in FIX, on MTHI/MTLO, or on reset.

Test Plan:
- WIDTH=32, FAST_MUL=0: MULT rs=0xFFFFFFFD (-3), rt=5 → done at edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high edges 1–32.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Repeat with FAST_MUL=1: same result, done after edge 1.
- DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 100 / 0 → lo=0xFFFFFFFF, hi=100, done after edge 1. MTHI 0x1234 then MTLO 0x5678 → hi=0x1234, lo=0x5678, busy=0 and done=0 throughout.
- Start DIVU 1000/7, assert flush at edge 10 → busy=0 from edge 11, no done, hi/lo unchanged. A start presented at edge 5 mid-op is ignored.
- Reset asserted at edge 15 of a MULT → hi=lo=0, busy=0, done=0. A new MULTU 6×7 afterwards gives lo=42, hi=0.
